// File: rtl/tone_pkg.sv
// Shared constants for the tone synthesiser and its I2S transmitter.
// Also holds the signed-sample helper that the top level uses.
package tone_pkg;

    localparam int DIV_W = 20;
    localparam int SMP_W = 16;
    localparam logic [SMP_W-1:0] AMP = 16'h1FFF;

    localparam int CLK_DIV_W = 11;
    localparam int MCLK_TAP  = 1;
    localparam int SCK_TAP   = 4;
    localparam int LRCK_TAP  = 10;
    localparam int SLOT_LEN  = 32;

    // Silence forces zero; otherwise a square wave of +/-(AMP >> vol)
    function automatic logic [SMP_W-1:0] form_sample(
        input logic       active,
        input logic       tone_level,
        input logic [2:0] vol
    );
        logic [SMP_W-1:0] amp;
        logic [SMP_W-1:0] result;
        amp    = AMP >> vol;
        result = '0;
        if (active) begin
            if (tone_level) begin
                result = amp;
            end else begin
                result = (~amp) + SMP_W'(1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: free-running clock divider plus 32-bit slot shifter.
// The same sample is reloaded at every LRCK edge, so both channels match.
module i2s_tx
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SMP_W-1:0] sample,
    output logic             audio_mclk,
    output logic             audio_sck,
    output logic             audio_lrck,
    output logic             audio_sdin
);

    localparam int PAD_W = SLOT_LEN - SMP_W - 1;

    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic [SLOT_LEN-1:0]  sr_q, sr_d;
    logic                 slot_end;
    logic                 sck_fall;

    // Last cycle of a channel slot; the next edge toggles LRCK and drops SCK
    assign slot_end = (div_q[LRCK_TAP-1:0] == '1);
    assign sck_fall = (div_q[SCK_TAP:0] == '1);

    always_comb begin
        div_d = div_q + CLK_DIV_W'(1);
    end

    always_comb begin
        sr_d = sr_q;
        if (slot_end) begin
            sr_d = {1'b0, sample, {PAD_W{1'b0}}};
        end else if (sck_fall) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sr_q  <= '0;
        end else begin
            div_q <= div_d;
            sr_q  <= sr_d;
        end
    end

    assign audio_mclk = div_q[MCLK_TAP];
    assign audio_sck  = div_q[SCK_TAP];
    assign audio_lrck = div_q[LRCK_TAP];
    assign audio_sdin = sr_q[SLOT_LEN-1];

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator driven by a half-period count, feeding an I2S DAC.
// A note_div of 0 silences both the raw tone and the audio sample.
module tone_synth
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] note_div,
    input  logic [2:0]       vol,
    output logic             tone,
    output logic             audio_mclk,
    output logic             audio_sck,
    output logic             audio_lrck,
    output logic             audio_sdin
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] note_q, note_d;
    logic             tone_q, tone_d;
    logic [SMP_W-1:0] sample;

    // A retune restarts the count but keeps the current phase of the wave
    always_comb begin
        note_d = note_div;
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (note_div == '0) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (note_div != note_q) begin
            cnt_d = '0;
        end else if (cnt_q == (note_div - DIV_W'(1))) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            note_q <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            note_q <= note_d;
            tone_q <= tone_d;
        end
    end

    assign sample = form_sample(note_q != '0, tone_q, vol);
    assign tone   = tone_q;

    i2s_tx u_i2s_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin)
    );

endmodule

// File: tb/tb_tone_synth.sv
// Scoreboard bench for tone_synth: a timestamp-based tone model and per-slot
// I2S words are queued by the driver and checked by an independent monitor.
module tb_tone_synth;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] note_div = '0;
    logic [2:0]  vol = '0;
    logic        tone, audio_mclk, audio_sck, audio_lrck, audio_sdin;

    tone_synth dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_div   (note_div),
        .vol        (vol),
        .tone       (tone),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .audio_sdin (audio_sdin)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tone;
        logic mclk;
        logic sck;
        logic lrck;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];
    int          total = 0;
    int          bad = 0;
    int          words_checked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model: tone is derived from the edge count since the last retune
    int          k;
    logic [19:0] m_note_q;
    logic        m_tone;
    int          seg_start;
    logic        seg_tone;

    task automatic model_reset();
        k         = 0;
        m_note_q  = '0;
        m_tone    = 1'b0;
        seg_start = 0;
        seg_tone  = 1'b0;
    endtask

    task automatic model_step(input logic [19:0] n, input logic [2:0] v);
        logic [15:0] amp;
        logic [15:0] w;
        int          d;
        int          toggles;
        exp_t        e;
        k++;
        if (k % 1024 == 0) begin
            amp = 16'h1FFF >> v;
            if (m_note_q == 0)  w = 16'h0000;
            else if (m_tone)    w = amp;
            else                w = 16'(-int'(amp));
            word_q.push_back(w);
        end
        if (n == 0) begin
            m_tone = 1'b0;
        end else if (n != m_note_q) begin
            seg_start = k;
            seg_tone  = m_tone;
        end else begin
            toggles = (k - seg_start) / int'(n);
            m_tone  = seg_tone ^ (toggles % 2 == 1);
        end
        m_note_q = n;
        d      = k % 2048;
        e.tone = m_tone;
        e.mclk = d[1];
        e.sck  = d[4];
        e.lrck = d[10];
        exp_q.push_back(e);
    endtask

    task automatic run(input int cycles, input logic [19:0] n, input logic [2:0] v);
        note_div = n;
        vol      = v;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            model_step(n, v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tone"}, 32'(tone), 32'd0);
        chk({tag, "_mclk"}, 32'(audio_mclk), 32'd0);
        chk({tag, "_sck"},  32'(audio_sck), 32'd0);
        chk({tag, "_lrck"}, 32'(audio_lrck), 32'd0);
        chk({tag, "_sdin"}, 32'(audio_sdin), 32'd0);
    endtask

    // Monitor: per-cycle pin checks and I2S slot deserialisation
    logic        prev_sck = 1'b0;
    logic        prev_lrck = 1'b0;
    logic        slot_on = 1'b0;
    int          nbits = 0;
    logic [31:0] slot = '0;
    exp_t        mon_e;
    logic [15:0] mon_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sck  = 1'b0;
            prev_lrck = 1'b0;
            slot_on   = 1'b0;
            nbits     = 0;
        end else begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("tone", 32'(tone), 32'(mon_e.tone));
                chk("mclk", 32'(audio_mclk), 32'(mon_e.mclk));
                chk("sck",  32'(audio_sck), 32'(mon_e.sck));
                chk("lrck", 32'(audio_lrck), 32'(mon_e.lrck));
            end
            if (audio_lrck != prev_lrck) begin
                slot_on = 1'b1;
                nbits   = 0;
            end
            if (slot_on && audio_sck && !prev_sck) begin
                slot = {slot[30:0], audio_sdin};
                nbits++;
                if (nbits == 32) begin
                    slot_on = 1'b0;
                    if (word_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL slot_unexpected actual=%h required=none at %0t", slot, $time);
                    end else begin
                        mon_w = word_q.pop_front();
                        chk("slot_word", slot, {1'b0, mon_w, 15'b0});
                        words_checked++;
                    end
                end
            end
            prev_sck  = audio_sck;
            prev_lrck = audio_lrck;
        end
    end

    initial begin
        logic [19:0] rn;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst_n = 1'b1;

        // Silence: tone low, zero slots, LRCK rises at cycle 1024
        run(2100, 20'd0, 3'd0);
        // Half-period 5, then retune to 3 mid-count
        run(37, 20'd5, 3'd0);
        run(30, 20'd3, 3'd0);
        run(20, 20'd1, 3'd0);
        // Low note at full volume, then attenuated
        run(2200, 20'd76628, 3'd0);
        run(2200, 20'd76628, 3'd2);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       rn = 20'd0;
                1:       rn = 20'($urandom_range(1, 8));
                2:       rn = 20'($urandom_range(100, 3000));
                default: rn = 20'($urandom);
            endcase
            run(int'($urandom_range(1, 700)), rn, 3'($urandom_range(0, 7)));
        end
        run(1100, 20'd3, 3'($urandom_range(0, 7)));

        // Asynchronous reset in the middle of a word at div = 600
        note_div = 20'd76628;
        vol      = 3'd0;
        while (k % 2048 != 600) run(1, 20'd76628, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        word_q.delete();
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        run(2200, 20'd76628, 3'd0);

        chk("words_seen", 32'(words_checked >= 10), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
